// File: rtl/cmp_pkg.sv
// Shared types and default sizes for the compare stage and its statistics collector.
package cmp_pkg;

    localparam int CMP_WIDTH = 8;
    localparam int CMP_CNT_W = 5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_res_t;

endpackage

// File: rtl/cmp_unit.sv
// Combinational unsigned magnitude comparator, shared with the upstream compare stage.
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    always_comb begin
        res = CMP_LT;
        if (a > b) begin
            res = CMP_GT;
        end else if (a == b) begin
            res = CMP_EQ;
        end
    end

endmodule

// File: rtl/cmp_stats_collector.sv
// Accepts a programmed number of operand pairs and accumulates compare statistics.
// state   | meaning
// IDLE    | waiting for start, results held
// RUN     | accepting pairs, in_ready/busy high
// DONE    | one-cycle done pulse, then back to IDLE
module cmp_stats_collector
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH,
    parameter int CNT_W = CMP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samp,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             status,
    output logic             st_valid,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [WIDTH-1:0] max_a,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             status_q, status_d;
    logic             st_valid_q, st_valid_d;
    cmp_res_t         res;
    logic             xfer;

    cmp_unit #(.WIDTH(WIDTH)) u_cmp (
        .a   (in_a),
        .b   (in_b),
        .res (res)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign xfer = in_valid && (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        max_d       = max_q;
        status_d    = status_q;
        st_valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = num_samp;
                    gt_d        = '0;
                    eq_d        = '0;
                    lt_d        = '0;
                    max_d       = '0;
                    status_d    = 1'b0;
                    state_d     = (num_samp == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    status_d    = (res == CMP_GT);
                    st_valid_d  = 1'b1;
                    case (res)
                        CMP_GT:  gt_d = sat_inc(gt_q);
                        CMP_EQ:  eq_d = sat_inc(eq_q);
                        default: lt_d = sat_inc(lt_q);
                    endcase
                    if (in_a > max_q) begin
                        max_d = in_a;
                    end
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            gt_q        <= '0;
            eq_q        <= '0;
            lt_q        <= '0;
            max_q       <= '0;
            status_q    <= 1'b0;
            st_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            max_q       <= max_d;
            status_q    <= status_d;
            st_valid_q  <= st_valid_d;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign status   = status_q;
    assign st_valid = st_valid_q;
    assign gt_cnt   = gt_q;
    assign eq_cnt   = eq_q;
    assign lt_cnt   = lt_q;
    assign max_a    = max_q;

endmodule

// File: tb/tb_cmp_stats_collector.sv
// Randomized and directed runs of cmp_stats_collector checked against a queue-based reference.
module tb_cmp_stats_collector;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] num_samp;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       status;
    logic       st_valid;
    logic [4:0] gt_cnt, eq_cnt, lt_cnt;
    logic [7:0] max_a;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pa[$];
    logic [7:0] pb[$];
    bit         pv[$];

    cmp_stats_collector #(.WIDTH(8), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_samp (num_samp),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .status   (status),
        .st_valid (st_valid),
        .gt_cnt   (gt_cnt),
        .eq_cnt   (eq_cnt),
        .lt_cnt   (lt_cnt),
        .max_a    (max_a),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ready"}, in_ready, 0);
        chk({pfx, "_status"}, status, 0);
        chk({pfx, "_stv"}, st_valid, 0);
        chk({pfx, "_gt"}, gt_cnt, 0);
        chk({pfx, "_eq"}, eq_cnt, 0);
        chk({pfx, "_lt"}, lt_cnt, 0);
        chk({pfx, "_max"}, max_a, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
    endtask

    // Runs one start..done sequence; abort_at >= 0 applies an async reset after that many transfers.
    task automatic do_run(input int n, input bit stall, input bit inj_start, input int abort_at);
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        int acc, cyc, egt, eeq, elt, emx;
        logic [7:0] a, b;
        bit v;
        start    = 1'b1;
        num_samp = 5'(n);
        step();
        start    = 1'b0;
        num_samp = 5'($urandom);
        chk("clr_gt", gt_cnt, 0);
        chk("clr_eq", eq_cnt, 0);
        chk("clr_lt", lt_cnt, 0);
        chk("clr_max", max_a, 0);
        chk("clr_status", status, 0);
        if (n == 0) begin
            chk("n0_done", done, 1);
            chk("n0_ready", in_ready, 0);
            chk("n0_busy", busy, 0);
            step();
            chk("n0_done_off", done, 0);
            chk("n0_ready_off", in_ready, 0);
            return;
        end
        acc = 0; cyc = 0; egt = 0; eeq = 0; elt = 0; emx = 0;
        while (acc < n && cyc < 400) begin
            chk("run_busy", busy, 1);
            chk("run_ready", in_ready, 1);
            chk("run_done", done, 0);
            if (pv.size() > 0) v = pv.pop_front();
            else v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (v && pa.size() > 0) begin
                a = pa.pop_front();
                b = pb.pop_front();
            end else begin
                a = 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            end
            in_valid = v;
            in_a     = a;
            in_b     = b;
            start    = inj_start && (cyc == 1);
            num_samp = 5'($urandom);
            step();
            start    = 1'b0;
            in_valid = 1'b0;
            cyc++;
            if (v) begin
                acc++;
                qa.push_back(a);
                qb.push_back(b);
                egt = 0; eeq = 0; elt = 0; emx = 0;
                foreach (qa[i]) begin
                    if (qa[i] > qb[i]) egt++;
                    else if (qa[i] == qb[i]) eeq++;
                    else elt++;
                    if (int'(qa[i]) > emx) emx = int'(qa[i]);
                end
                if (egt > 31) egt = 31;
                if (eeq > 31) eeq = 31;
                if (elt > 31) elt = 31;
                chk("xfer_status", status, (a > b) ? 1 : 0);
                chk("xfer_stv", st_valid, 1);
                chk("xfer_gt", gt_cnt, egt);
                chk("xfer_eq", eq_cnt, eeq);
                chk("xfer_lt", lt_cnt, elt);
                chk("xfer_max", max_a, emx);
            end else begin
                chk("gap_stv", st_valid, 0);
            end
            if (abort_at >= 0 && acc == abort_at) begin
                #2 rst = 1'b1;
                #1;
                chk_all_zero("async");
                @(negedge clk);
                chk("abort_done", done, 0);
                @(negedge clk);
                rst = 1'b0;
                step();
                chk_all_zero("post_abort");
                return;
            end
        end
        chk("xfer_count", acc, n);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = 8'd200;
            in_b     = 8'd100;
            step();
            chk("hold_done", done, 0);
            chk("hold_ready", in_ready, 0);
            chk("hold_stv", st_valid, 0);
            chk("hold_gt", gt_cnt, egt);
            chk("hold_eq", eq_cnt, eeq);
            chk("hold_lt", lt_cnt, elt);
            chk("hold_max", max_a, emx);
            chk("hold_status", status, (qa[n-1] > qb[n-1]) ? 1 : 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samp = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("idle");

        pa = '{8'd9, 8'd4, 8'd2};
        pb = '{8'd1, 8'd4, 8'd7};
        do_run(3, 1'b0, 1'b0, -1);

        do_run(0, 1'b0, 1'b0, -1);

        pv = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_run(2, 1'b0, 1'b0, -1);

        for (int i = 0; i < 31; i++) begin
            pa.push_back(8'd200);
            pb.push_back(8'd100);
        end
        do_run(31, 1'b0, 1'b0, -1);

        do_run(5, 1'b1, 1'b1, -1);

        do_run(6, 1'b1, 1'b0, 2);
        do_run(7, 1'b1, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            do_run($urandom_range(1, 31), 1'b1, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
